// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the hazard scoreboard.
//   sb_entry_t    : one in-flight writer slot {valid, rd, is_load}
//   FWD_SEL_RF    : forward-select code meaning "read the register file"
//   fwd_sel_width : width of a forward select for a given scoreboard depth
package hazard_scoreboard_pkg;

  // Slot register field is sized for the widest supported specifier; narrower
  // specifiers are zero-extended on entry and on compare.
  localparam int unsigned SB_REG_W_MAX = 8;

  localparam int unsigned FWD_SEL_RF = 0;

  typedef struct packed {
    logic                    valid;
    logic [SB_REG_W_MAX-1:0] rd;
    logic                    is_load;
  } sb_entry_t;

  // Select codes: 0 = register file, k+1 = slot k.
  function automatic int unsigned fwd_sel_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Priority match of one decode source against every scoreboard slot.
//   slots_i     : registered scoreboard slots (index 0 = EX)
//   src_i       : source register specifier
//   src_valid_i : source is actually read
//   qual_i      : decode instruction is valid and not flushed
//   hit_c       : some slot matches
//   idx_c       : youngest (lowest-index) matching slot
//   is_load_c   : is_load flag of that youngest slot
module hazard_src_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned REG_W       = 3,
  parameter int unsigned ZERO_REG_EN = 0
) (
  input  sb_entry_t [DEPTH-1:0]         slots_i,
  input  logic [REG_W-1:0]              src_i,
  input  logic                          src_valid_i,
  input  logic                          qual_i,
  output logic                          hit_c,
  output logic [$clog2(DEPTH)-1:0]      idx_c,
  output logic                          is_load_c
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic                    src_live;
  logic [SB_REG_W_MAX-1:0] src_ext;

  // Scan oldest to youngest so the lowest matching index is the one kept.
  always_comb begin
    hit_c     = 1'b0;
    idx_c     = '0;
    is_load_c = 1'b0;
    src_ext   = SB_REG_W_MAX'(src_i);
    src_live  = src_valid_i && qual_i &&
                !((ZERO_REG_EN != 0) && (src_i == '0));
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (src_live && slots_i[k].valid && (slots_i[k].rd == src_ext)) begin
        hit_c     = 1'b1;
        idx_c     = IDX_W'(k);
        is_load_c = slots_i[k].is_load;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard scoreboard tracking DEPTH in-flight writers (EX..WB).
//   clk, rst          : clock, synchronous active-high reset
//   d_*               : decode instruction sources, destination and load flag
//   hold              : global freeze, scoreboard and counter retain state
//   flush             : squash decode instruction (no stall, no issue)
//   stall             : combinational decode stall
//   fwd_rs/rt_sel     : combinational forward selects (0 = register file)
//   pipe_valid        : per-slot valid bits
//   stall_cnt         : saturating count of stalled, non-held cycles
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_W       = 3,
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned FWD_EN      = 1,
  parameter int unsigned ZERO_REG_EN = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              d_valid,
  input  logic [REG_W-1:0]                  d_rs,
  input  logic                              d_rs_valid,
  input  logic [REG_W-1:0]                  d_rt,
  input  logic                              d_rt_valid,
  input  logic                              d_wr_en,
  input  logic [REG_W-1:0]                  d_wr_reg,
  input  logic                              d_is_load,
  input  logic                              hold,
  input  logic                              flush,
  output logic                              stall,
  output logic [fwd_sel_width(DEPTH)-1:0]   fwd_rs_sel,
  output logic [fwd_sel_width(DEPTH)-1:0]   fwd_rt_sel,
  output logic [DEPTH-1:0]                  pipe_valid,
  output logic [CNT_W-1:0]                  stall_cnt
);

  localparam int unsigned SEL_W = fwd_sel_width(DEPTH);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  sb_entry_t [DEPTH-1:0] slots_q, slots_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic             qual_c;
  logic             rs_hit, rt_hit;
  logic [IDX_W-1:0] rs_idx, rt_idx;
  logic             rs_ld, rt_ld;
  logic             rs_haz_fwd, rt_haz_fwd;
  logic             rs_haz_nof, rt_haz_nof;

  assign qual_c = d_valid && !flush;

  hazard_src_match #(
    .DEPTH       (DEPTH),
    .REG_W       (REG_W),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_rs_match (
    .slots_i     (slots_q),
    .src_i       (d_rs),
    .src_valid_i (d_rs_valid),
    .qual_i      (qual_c),
    .hit_c       (rs_hit),
    .idx_c       (rs_idx),
    .is_load_c   (rs_ld)
  );

  hazard_src_match #(
    .DEPTH       (DEPTH),
    .REG_W       (REG_W),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_rt_match (
    .slots_i     (slots_q),
    .src_i       (d_rt),
    .src_valid_i (d_rt_valid),
    .qual_i      (qual_c),
    .hit_c       (rt_hit),
    .idx_c       (rt_idx),
    .is_load_c   (rt_ld)
  );

  // Stall and forward selects. With forwarding only a load still in EX
  // blocks; without it anything short of WB blocks, since WB writes the
  // register file in time for the decode read.
  always_comb begin
    rs_haz_fwd = rs_hit && (rs_idx == '0) && rs_ld;
    rt_haz_fwd = rt_hit && (rt_idx == '0) && rt_ld;
    rs_haz_nof = rs_hit && (rs_idx != IDX_W'(DEPTH - 1));
    rt_haz_nof = rt_hit && (rt_idx != IDX_W'(DEPTH - 1));
    fwd_rs_sel = SEL_W'(FWD_SEL_RF);
    fwd_rt_sel = SEL_W'(FWD_SEL_RF);
    if (FWD_EN != 0) begin
      stall = rs_haz_fwd || rt_haz_fwd;
      if (!stall) begin
        if (rs_hit) fwd_rs_sel = SEL_W'(rs_idx) + SEL_W'(1);
        if (rt_hit) fwd_rt_sel = SEL_W'(rt_idx) + SEL_W'(1);
      end
    end else begin
      stall = rs_haz_nof || rt_haz_nof;
    end
  end

  // Shift the scoreboard one stage per unfrozen cycle; stall/flush issue a bubble.
  always_comb begin
    slots_d = slots_q;
    cnt_d   = cnt_q;
    if (!hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        slots_d[k] = slots_q[k-1];
      end
      slots_d[0].valid   = d_valid && d_wr_en && !stall && !flush;
      slots_d[0].rd      = SB_REG_W_MAX'(d_wr_reg);
      slots_d[0].is_load = d_is_load;
      if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q <= '0;
      cnt_q   <= '0;
    end else begin
      slots_q <= slots_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pipe_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pipe_valid[k] = slots_q[k].valid;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-entry decode stall unit.
- Tracks up to DEPTH in-flight register writers (EX..WB) in a shift-register scoreboard.
- Raises a decode stall on RAW hazards and, in forwarding mode, produces per-source forwarding selects so only load-use hazards stall.
- Sits beside the decode stage and also provides a saturating stall-cycle counter for performance measurement.

Parameters:
- REG_W, 3: register-specifier width.
- DEPTH, 3: in-flight writer slots. Index 0 = EX, index DEPTH-1 = WB. Legal range 2..8.
- FWD_EN, 1: 1 = forwarding datapath present (only load-use stalls); 0 = stall until the writer reaches WB.
- ZERO_REG_EN, 0: 1 = register 0 is hard-wired and never creates a hazard.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- d_valid  in  1  a valid instruction is in decode.
- d_rs  in  REG_W  source 1 specifier.
- d_rs_valid  in  1  source 1 is actually read.
- d_rt  in  REG_W  source 2 specifier.
- d_rt_valid  in  1  source 2 is actually read.
- d_wr_en  in  1  decode instruction writes the register file.
- d_wr_reg  in  REG_W  destination specifier.
- d_is_load  in  1  destination value comes from memory.
- hold  in  1  global pipeline freeze (memory busy).
- flush  in  1  squash the decode instruction this cycle.
- stall  out  1  hold IF/ID and inject a bubble into EX.
- fwd_rs_sel  out  $clog2(DEPTH+1)  source 1 forward select.
- fwd_rt_sel  out  $clog2(DEPTH+1)  source 2 forward select.
- pipe_valid  out  DEPTH  valid bit per scoreboard slot (debug).
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Storage: DEPTH slots, each holding {valid, reg[REG_W-1:0], is_load}.
- Reset: all slot valids = 0, stall_cnt = 0. With an empty scoreboard, stall = 0 and both selects = 0.
- Match rule: slot k matches source S when valid[k] && reg[k]==S && S_valid && d_valid && !flush, and not (ZERO_REG_EN && S==0).
- Youngest match (lowest k) takes priority.
- FWD_EN=1:
  - Hazard on S when the youngest match is slot 0 with is_load=1.
  - fwd_S_sel = k+1 for youngest match k; 0 = register file.
  - When stall=1, both selects are forced to 0.
- FWD_EN=0:
  - Hazard on S when any match exists in slots 0..DEPTH-2. WB (slot DEPTH-1) is bypassed by the register file.
  - Selects are always 0.
- stall = hazard(rs) | hazard(rt). Combinational from registered slots plus decode inputs, zero-cycle latency.
- Sequential update on posedge clk, in priority order:
  - rst: all valids cleared; stall_cnt cleared. Reset mid-operation discards every in-flight entry.
  - hold=1: all slots retain their contents; stall_cnt unchanged.
  - Otherwise the slots shift: slot k+1 <= slot k, and the slot DEPTH-1 entry retires.
  - Slot 0 loads {d_valid && d_wr_en && !stall && !flush, d_wr_reg, d_is_load}. A stall or flush therefore inserts a bubble.
- flush has priority over hazards: flush=1 forces stall=0 and issues nothing.
- A writer to reg 0 with ZERO_REG_EN=1 is still tracked but never matches.
- stall_cnt increments when stall && !hold, and saturates at all ones with no wrap.
- A stalled instruction re-evaluates every cycle. A load-use stall (FWD_EN=1) lasts exactly 1 cycle absent hold. Without forwarding, stall lasts up to DEPTH-1 cycles.

Decomposition:
- Shared package holds:
  - typedef sb_entry_t {valid, reg, is_load}.
  - FWD_SEL_RF = 0.
  - The function computing the select width from DEPTH.
- One natural sub-module, hazard_src_match: one instance per source. It performs the priority match across slots and returns {hit, youngest_idx, youngest_is_load}.
- The top holds the slot shift register, stall combine and counter.

Test Plan:
1. Reset then idle: d_valid=0 for 5 cycles -> stall=0, selects=0, pipe_valid=0, stall_cnt=0.
2. FWD_EN=1, load r2 issued, next cycle d_rs=2 valid -> stall=1 for exactly 1 cycle, stall_cnt=1. Next cycle fwd_rs_sel=2 (slot 1), stall=0.
3. FWD_EN=1, ALU writes r3 at slots 0 and 2 (two writers), d_rt=3 -> stall=0, fwd_rt_sel=1 (youngest wins).
4. FWD_EN=0, DEPTH=3, ALU writes r1 then d_rs=1 -> stall=1 for 2 cycles, then stall=0 with sel=0 while the writer is in WB.
5. Load r4 then d_rs=4 with hold=1 for 3 cycles -> stall stays 1, slots frozen, stall_cnt unchanged. After hold drops, 1 stall cycle occurs, then release.
6. Load r5 then d_rs=5 with flush=1 -> stall=0, bubble enters slot 0. Also check with ZERO_REG_EN=1: load r0 then d_rs=0 -> stall=0.
